upsample_2d: RTL

Nearest-neighbour 2D upsampler: the inverse of downsample_2d. Takes a valid/ready raster stream of in_width x in_height pixels and emits in_width*up_factor x in_height*up_factor pixels. Each input pixel is repeated up_factor times horizontally, and each row is repeated up_factor times vertically. It sits after bram_filter_system, restoring decimated disparity/gray output to full frame resolution for display and for comparison against full-res reference data.

---
 rtl/upsample_2d.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/upsample_2d.sv
// Nearest-neighbour 2D upsampler: each input pixel is repeated up_factor times per row,
// and each row is replayed up_factor-1 more times from a single-row line buffer.
module upsample_2d #(
    parameter int up_factor  = 2,
    parameter int in_width   = 120,
    parameter int in_height  = 240,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int XW = (up_factor > 1) ? $clog2(up_factor) : 1;
    localparam int CW = (in_width > 1) ? $clog2(in_width) : 1;
    localparam int RW = (in_height > 1) ? $clog2(in_height) : 1;
    localparam logic [XW-1:0] REP_LAST = XW'(up_factor - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(in_width - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(in_height - 1);
    localparam bit MULTI = (up_factor > 1);

    typedef enum logic [0:0] {
        LIVE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [XW-1:0]         rep_x_r, rep_x_s;
    logic [XW-1:0]         rep_y_r, rep_y_s;
    logic [CW-1:0]         col_r, col_s;
    logic [RW-1:0]         row_r, row_s;
    logic                  out_valid_r, out_valid_s;
    logic [data_width-1:0] out_data_r, out_data_s;
    logic [data_width-1:0] linebuf_r [in_width];

    logic          in_ready_s;
    logic          in_fire_s;
    logic          out_fire_s;
    logic          last_rep_s;
    logic          wr_en_s;
    logic [CW-1:0] wr_col_s;
    logic [CW-1:0] col_inc_s;
    logic [RW-1:0] row_inc_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Next-state, handshake and line-buffer access decode.
    always_comb begin
        state_s     = state_r;
        rep_x_s     = rep_x_r;
        rep_y_s     = rep_y_r;
        col_s       = col_r;
        row_s       = row_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        wr_en_s     = 1'b0;
        wr_col_s    = col_r;
        in_ready_s  = 1'b0;
        in_fire_s   = 1'b0;
        out_fire_s  = out_valid_r & out_ready;
        last_rep_s  = (rep_x_r == REP_LAST);
        col_inc_s   = (col_r == COL_LAST) ? CW'(0) : col_r + CW'(1);
        row_inc_s   = (row_r == ROW_LAST) ? RW'(0) : row_r + RW'(1);

        case (state_r)
            LIVE: begin
                // The last pixel of a row must not be overlapped by a new input when a replay follows.
                in_ready_s = !reset && (!out_valid_r ||
                             (out_ready && last_rep_s && !(MULTI && (col_r == COL_LAST))));
                in_fire_s  = in_valid & in_ready_s;
                if (out_fire_s) begin
                    if (!last_rep_s) begin
                        rep_x_s = rep_x_r + XW'(1);
                    end else begin
                        rep_x_s     = XW'(0);
                        out_valid_s = 1'b0;
                        col_s       = col_inc_s;
                        if (col_r == COL_LAST) begin
                            if (MULTI) begin
                                state_s = REPLAY;
                                rep_y_s = XW'(1);
                            end else begin
                                row_s = row_inc_s;
                            end
                        end else begin
                            row_s = row_r;
                        end
                    end
                end else begin
                    rep_x_s = rep_x_r;
                end
                if (in_fire_s) begin
                    out_data_s  = in_data;
                    out_valid_s = 1'b1;
                    rep_x_s     = XW'(0);
                    wr_en_s     = 1'b1;
                    wr_col_s    = col_s;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            REPLAY: begin
                // out_valid low here is the prefetch bubble that opens every replay row.
                if (!out_valid_r) begin
                    out_valid_s = 1'b1;
                    out_data_s  = linebuf_r[col_r];
                end else if (out_fire_s) begin
                    if (!last_rep_s) begin
                        rep_x_s = rep_x_r + XW'(1);
                    end else begin
                        rep_x_s = XW'(0);
                        if (col_r != COL_LAST) begin
                            col_s      = col_inc_s;
                            out_data_s = linebuf_r[col_inc_s];
                        end else begin
                            col_s       = CW'(0);
                            out_valid_s = 1'b0;
                            if (rep_y_r != REP_LAST) begin
                                rep_y_s = rep_y_r + XW'(1);
                            end else begin
                                rep_y_s = XW'(0);
                                row_s   = row_inc_s;
                                state_s = LIVE;
                            end
                        end
                    end
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            default: begin
                state_s = LIVE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= LIVE;
            rep_x_r     <= XW'(0);
            rep_y_r     <= XW'(0);
            col_r       <= CW'(0);
            row_r       <= RW'(0);
            out_valid_r <= 1'b0;
            out_data_r  <= {data_width{1'b0}};
        end else begin
            state_r     <= state_s;
            rep_x_r     <= rep_x_s;
            rep_y_r     <= rep_y_s;
            col_r       <= col_s;
            row_r       <= row_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
        end
    end

    // Line buffer write port; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            linebuf_r[wr_col_s] <= in_data;
        end
    end

endmodule
